pipelined_complement_unit: RTL and testbench

- Parametrised, pipelined successor to the single-bit inverter used across the FP multiplier datapath.
- Applies one of four complement operations to a W-bit word, selected per transaction: pass, ones' complement, two's-complement negate, absolute value.
- Sits between the mantissa/exponent datapath and the sign-magnitude conversion and exponent-bias logic.
- Valid/ready handshake on both sides; configurable pipeline depth with stall-aware bubble collapsing.

---
 rtl/complement_pkg.sv | 23 ++
 rtl/complement_pipe_stage.sv | 48 ++++
 rtl/pipelined_complement_unit.sv | 123 ++++++++++++
 tb/tb_pipelined_complement_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complement_pkg.sv
`default_nettype none
// ============================================================================
// Module   : complement_pkg
// Purpose  : Shared definitions for the pipelined complement unit: operation
//            mode encoding and the legal ranges of the unit's parameters.
// Revision : 1.0 - initial release
// ============================================================================
package complement_pkg;

    // Operation selector carried with each transaction
    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NOT  = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_ABS  = 2'b11;

    // Supported parameter ranges
    localparam int c_W_MIN      = 2;
    localparam int c_W_MAX      = 128;
    localparam int c_STAGES_MIN = 1;
    localparam int c_STAGES_MAX = 4;

endpackage : complement_pkg
`default_nettype wire

// File: rtl/complement_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : complement_pipe_stage
// Purpose  : One pipeline slot of the complement unit: a valid flag plus a
//            payload register. When i_load is high the slot takes whatever
//            the upstream side offers (word or bubble); otherwise it holds.
// Ports    : clk, rst (async, active-high)
//            i_load            - slot is free or its word moves on this cycle
//            i_valid/i_payload - upstream slot (or the operation logic)
//            o_valid/o_payload - slot contents
// Revision : 1.0 - initial release
// ============================================================================
module complement_pipe_stage
    import complement_pkg::*;
#(
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_valid,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_valid,
    output logic [PAYLOAD_W-1:0] o_payload
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;

    // The payload only changes when a real word arrives; a bubble clears the
    // valid flag but leaves the last data in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_payload <= i_payload;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_payload = r_payload;

endmodule : complement_pipe_stage
`default_nettype wire

// File: rtl/pipelined_complement_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_complement_unit
// Purpose  : Applies PASS / NOT / NEG / ABS to a W-bit word and delivers the
//            result through STAGES valid/ready pipeline slots with bubble
//            collapsing (any empty slot lets a new word in).
// Ports    : clk, rst (async, active-high)
//            in_valid, in_ready, in_data[W-1:0], in_mode[1:0]
//            out_valid, out_ready, out_data[W-1:0]
//            out_ovf  - only when COMPLEMENT_OVF_FLAG_EN is defined; set for
//                       NEG/ABS of the minimum value (MSB only set)
// Options  : `define COMPLEMENT_OVF_FLAG_EN adds the out_ovf port and carries
//            the flag as an extra payload bit through every stage.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_complement_unit
    import complement_pkg::*;
#(
    parameter int W      = 64,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
`ifdef COMPLEMENT_OVF_FLAG_EN
    ,
    output logic         out_ovf
`endif
);

`ifdef COMPLEMENT_OVF_FLAG_EN
    localparam int c_OVF_W = 1;
`else
    localparam int c_OVF_W = 0;
`endif
    localparam int          c_PW   = W + c_OVF_W;
    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] c_MIN = {1'b1, {(W-1){1'b0}}};

    // Operation logic; the ovf flag (when present) sits above the data bits.
    // Negating the minimum value wraps back onto itself, which is exactly
    // the case the flag reports.
    function automatic logic [c_PW-1:0] f_complement(input logic [W-1:0] a,
                                                     input logic [1:0]   mode);
        logic [W-1:0] v_neg;
        logic [W-1:0] v_res;
        logic         v_ovf;
        v_neg = ~a + c_ONE;
        case (mode)
            MODE_PASS: v_res = a;
            MODE_NOT:  v_res = ~a;
            MODE_NEG:  v_res = v_neg;
            default:   v_res = a[W-1] ? v_neg : a;
        endcase
        v_ovf = ((mode == MODE_NEG) || (mode == MODE_ABS)) && (a == c_MIN);
`ifdef COMPLEMENT_OVF_FLAG_EN
        return {v_ovf, v_res};
`else
        return v_res;
`endif
    endfunction

    logic [c_PW-1:0] w_op_result;
    logic            w_valid   [STAGES];
    logic [c_PW-1:0] w_payload [STAGES];
    logic [STAGES:0] w_rdy;

    always_comb begin
        w_op_result = f_complement(in_data, in_mode);
    end

    // Slot k may load when it is empty or when slot k+1 can take its word;
    // the end of the chain is the downstream ready. Any bubble anywhere
    // therefore propagates readiness to the input.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = !w_valid[k] || w_rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic            w_src_valid;
        logic [c_PW-1:0] w_src_payload;

        if (k == 0) begin : g_head
            assign w_src_valid   = in_valid;
            assign w_src_payload = w_op_result;
        end else begin : g_tail
            assign w_src_valid   = w_valid[k-1];
            assign w_src_payload = w_payload[k-1];
        end

        complement_pipe_stage #(
            .PAYLOAD_W (c_PW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_load    (w_rdy[k]),
            .i_valid   (w_src_valid),
            .i_payload (w_src_payload),
            .o_valid   (w_valid[k]),
            .o_payload (w_payload[k])
        );
    end

    // Held low throughout reset even though the slots read as empty
    assign in_ready  = !rst && w_rdy[0];
    assign out_valid = w_valid[STAGES-1];
    assign out_data  = w_payload[STAGES-1][W-1:0];
`ifdef COMPLEMENT_OVF_FLAG_EN
    assign out_ovf   = w_payload[STAGES-1][W];
`endif

endmodule : pipelined_complement_unit
`default_nettype wire

// File: tb/tb_pipelined_complement_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_complement_unit
// Purpose  : Self-checking bench. Five unit instances of different W/STAGES
//            share one stimulus stream; each has its own expected-result
//            queue built from the arithmetic definition of the operations.
// Options  : honours COMPLEMENT_OVF_FLAG_EN (out_ovf checked when defined)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_complement_unit;
    import complement_pkg::*;

    localparam int N = 5;
`ifdef COMPLEMENT_OVF_FLAG_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    function automatic int cfg_w(input int k);
        case (k)
            0: return 64;
            1: return 8;
            2: return 8;
            3: return 53;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_s(input int k);
        case (k)
            0: return 2;
            1: return 4;
            2: return 1;
            3: return 3;
            default: return 3;
        endcase
    endfunction

    // Reference: result = {ovf, value} computed modulo 2^w
    function automatic logic [64:0] model(input logic [63:0] a_in,
                                          input logic [1:0] m, input int w);
        logic [64:0] full, mask, a, half, neg, res;
        logic        ovf;
        full = 65'd1 << w;
        mask = full - 65'd1;
        a    = {1'b0, a_in} & mask;
        half = full >> 1;
        neg  = (full - a) & mask;
        case (m)
            MODE_PASS: res = a;
            MODE_NOT:  res = mask ^ a;
            MODE_NEG:  res = neg;
            default:   res = (a >= half) ? neg : a;
        endcase
        ovf = ((m == MODE_NEG) || (m == MODE_ABS)) && (a == half);
        return {ovf & OVF_ON, res[63:0]};
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] tb_data;
    logic [1:0]  tb_mode;

    logic        rdy_a [N];
    logic        ov_a  [N];
    logic [64:0] od_a  [N];

    logic [63:0] d0;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [52:0] d3;
    logic [63:0] d4;
    logic        f0, f1, f2, f3, f4;

    always #5 clk = ~clk;

    pipelined_complement_unit #(.W(64), .STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a[0]),
        .in_data(tb_data[63:0]), .in_mode(tb_mode), .out_valid(ov_a[0]),
        .out_ready(out_ready), .out_data(d0)
`ifdef COMPLEMENT_OVF_FLAG_EN
        , .out_ovf(f0)
`endif
    );
    pipelined_complement_unit #(.W(8), .STAGES(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a[1]),
        .in_data(tb_data[7:0]), .in_mode(tb_mode), .out_valid(ov_a[1]),
        .out_ready(out_ready), .out_data(d1)
`ifdef COMPLEMENT_OVF_FLAG_EN
        , .out_ovf(f1)
`endif
    );
    pipelined_complement_unit #(.W(8), .STAGES(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a[2]),
        .in_data(tb_data[7:0]), .in_mode(tb_mode), .out_valid(ov_a[2]),
        .out_ready(out_ready), .out_data(d2)
`ifdef COMPLEMENT_OVF_FLAG_EN
        , .out_ovf(f2)
`endif
    );
    pipelined_complement_unit #(.W(53), .STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a[3]),
        .in_data(tb_data[52:0]), .in_mode(tb_mode), .out_valid(ov_a[3]),
        .out_ready(out_ready), .out_data(d3)
`ifdef COMPLEMENT_OVF_FLAG_EN
        , .out_ovf(f3)
`endif
    );
    pipelined_complement_unit #(.W(64), .STAGES(3)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a[4]),
        .in_data(tb_data[63:0]), .in_mode(tb_mode), .out_valid(ov_a[4]),
        .out_ready(out_ready), .out_data(d4)
`ifdef COMPLEMENT_OVF_FLAG_EN
        , .out_ovf(f4)
`endif
    );

`ifndef COMPLEMENT_OVF_FLAG_EN
    assign f0 = 1'b0;
    assign f1 = 1'b0;
    assign f2 = 1'b0;
    assign f3 = 1'b0;
    assign f4 = 1'b0;
`endif

    assign od_a[0] = {f0, d0};
    assign od_a[1] = {f1, 56'b0, d1};
    assign od_a[2] = {f2, 56'b0, d2};
    assign od_a[3] = {f3, 11'b0, d3};
    assign od_a[4] = {f4, d4};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int k,
                       input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    // Scoreboard state (written only by the compare process below)
    logic [64:0] mem       [N][16];
    int          head      [N];
    int          tail      [N];
    int          cnt       [N];
    int          acc_cnt   [N];
    int          drn_cnt   [N];
    logic [64:0] last_out  [N];
    logic        prev_stall[N];
    logic [64:0] prev_data [N];

    initial begin
        for (int k = 0; k < N; k++) begin
            head[k] = 0; tail[k] = 0; cnt[k] = 0;
            acc_cnt[k] = 0; drn_cnt[k] = 0;
            last_out[k] = '0; prev_stall[k] = 1'b0; prev_data[k] = '0;
        end
    end

    // Compare process: inputs are driven just after the rising edge, so the
    // values seen on the falling edge are exactly what the next edge uses.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                head[k] = 0; tail[k] = 0; cnt[k] = 0;
                prev_stall[k] = 1'b0;
                chk("reset_in_ready", k, 65'(rdy_a[k]), 65'd0);
                chk("reset_out_valid", k, 65'(ov_a[k]), 65'd0);
                chk("reset_out_data", k, od_a[k], 65'd0);
            end else begin
                chk("in_ready", k, 65'(rdy_a[k]),
                    65'(out_ready || (cnt[k] < cfg_s(k))));
                if (prev_stall[k]) begin
                    chk("stall_hold_valid", k, 65'(ov_a[k]), 65'd1);
                    chk("stall_hold_data", k, od_a[k], prev_data[k]);
                end
                if (ov_a[k] && cnt[k] == 0) begin
                    chk("spurious_out_valid", k, 65'(ov_a[k]), 65'd0);
                end
                if (ov_a[k] && out_ready && cnt[k] > 0) begin
                    chk("result", k, od_a[k], mem[k][head[k]]);
                    head[k] = (head[k] + 1) % 16;
                    cnt[k]--;
                    drn_cnt[k]++;
                    last_out[k] = od_a[k];
                end
                if (in_valid && rdy_a[k]) begin
                    mem[k][tail[k]] = model(tb_data, tb_mode, cfg_w(k));
                    tail[k] = (tail[k] + 1) % 16;
                    cnt[k]++;
                    acc_cnt[k]++;
                end
                prev_stall[k] = ov_a[k] && !out_ready;
                prev_data[k]  = od_a[k];
            end
        end
    end

    // One word into empty pipelines with out_ready high; every instance must
    // raise out_valid in exactly the cycle STAGES after presentation.
    task automatic send_one(input logic [63:0] d, input logic [1:0] m);
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) chk("idle_in_ready", k, 65'(rdy_a[k]), 65'd1);
        in_valid = 1'b1; tb_data = d; tb_mode = m; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++)
                chk("latency", k, 65'(ov_a[k]), 65'(i == cfg_s(k)));
            @(posedge clk); #1;
        end
    endtask

    task automatic mode_w8(input logic [7:0] d, input logic [1:0] m,
                           input logic [7:0] exp, input logic ovf);
        send_one({56'b0, d}, m);
        chk("mode_w8", 1, last_out[1], {ovf, 56'b0, exp});
    endtask

    int snap_acc [N];
    int snap_drn;
    int seq;
    int stall_left;
    int sel;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tb_data = '0; tb_mode = MODE_PASS;

        // Reset and first-result latency
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("t1_rst_out_valid", 0, 65'(ov_a[0]), 65'd0);
        chk("t1_rst_out_data", 0, od_a[0], 65'd0);
        chk("t1_rst_in_ready", 0, 65'(rdy_a[0]), 65'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        send_one(64'h0, MODE_NOT);
        chk("t1_not_zero", 0, last_out[0], {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});

        // Operation table on the 8-bit instance
        mode_w8(8'h05, MODE_NEG, 8'hFB, 1'b0);
        mode_w8(8'hFB, MODE_ABS, 8'h05, 1'b0);
        mode_w8(8'h05, MODE_ABS, 8'h05, 1'b0);
        mode_w8(8'hA5, MODE_PASS, 8'hA5, 1'b0);
        mode_w8(8'hA5, MODE_NOT, 8'h5A, 1'b0);
        mode_w8(8'h00, MODE_NEG, 8'h00, 1'b0);
        mode_w8(8'h80, MODE_NEG, 8'h80, OVF_ON);
        mode_w8(8'h80, MODE_ABS, 8'h80, OVF_ON);
        send_one(64'h8000_0000_0000_0000, MODE_ABS);
        chk("min_abs_w64", 0, last_out[0], {OVF_ON, 64'h8000_0000_0000_0000});

        // Backpressure: 10 sequential words, downstream stalled cycles 3..8
        seq = 0;
        snap_drn = drn_cnt[0];
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc <= 8);
            in_valid  = (seq < 10);
            tb_data   = 64'(seq);
            tb_mode   = MODE_NOT;
            @(negedge clk); #1;
            if (in_valid && rdy_a[0]) seq++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 0, 65'(seq), 65'd10);
        chk("bp_all_drained", 0, 65'(drn_cnt[0] - snap_drn), 65'd10);

        // Bubble collapse: alternate-cycle pulses into a stalled output
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) snap_acc[k] = acc_cnt[k];
        for (int i = 0; i < 12; i++) begin
            in_valid = (i % 2 == 0);
            tb_data  = 64'h100 + 64'(i);
            tb_mode  = MODE_NEG;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        for (int k = 0; k < N; k++) begin
            chk("bubble_accepted", k, 65'(acc_cnt[k] - snap_acc[k]), 65'(cfg_s(k)));
            chk("bubble_full_in_ready", k, 65'(rdy_a[k]), 65'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);

        // Asynchronous reset with two words in flight
        #1;
        in_valid = 1'b1; tb_data = 64'h11; tb_mode = MODE_PASS;
        @(posedge clk); #1;
        tb_data = 64'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) chk("async_rst_out_valid", k, 65'(ov_a[k]), 65'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        send_one(64'h33, MODE_NEG);
        chk("post_rst_first_w64", 0, last_out[0], {1'b0, 64'hFFFF_FFFF_FFFF_FFCD});
        chk("post_rst_first_w8", 1, last_out[1], {1'b0, 56'b0, 8'hCD});

        // Random traffic against the scoreboard
        stall_left = 0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            tb_mode  = 2'($urandom_range(0, 3));
            sel      = $urandom_range(0, 9);
            case (sel)
                0: tb_data = 64'h0;
                1: tb_data = 64'h80;
                2: tb_data = 64'h8000_0000_0000_0000;
                3: tb_data = 64'h0010_0000_0000_0000;
                default: tb_data = {$urandom, $urandom};
            endcase
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 63) == 0) stall_left = $urandom_range(2, 10);
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        for (int k = 0; k < N; k++) chk("drained_empty", k, 65'(cnt[k]), 65'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipelined_complement_unit
`default_nettype wire
